imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 179 +++++++++++++++++
 tb/tb_imem_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : UART-fed boot loader that writes checksummed program images
//               into instruction memory and gates the core's reset.
// Revision    : 1.0
// ============================================================================
module imem_loader #(
  parameter int         ADDR_W   = 8,
  parameter logic [7:0] HDR_BYTE = 8'hA5,
  parameter int         TIMEOUT  = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    DATA    = 3'd2,
    CSUM    = 3'd3,
    DONE_ST = 3'd4
  } state_t;

  state_t        state, state_nx;

  logic [7:0]    len;
  logic [8:0]    widx;
  logic [1:0]    lane;
  logic [23:0]   asm_lo;
  logic [7:0]    xsum;
  logic [TW-1:0] tcnt;

  logic [8:0]    word_total;
  logic          last_word;
  logic          in_frame;
  logic          tmo;
  logic          start;
  logic          data_byte;
  logic          fail;
  logic          pass;

  // N=0 encodes a full 256-word image
  assign word_total = (len == 8'd0) ? 9'd256 : {1'b0, len};
  assign last_word  = ((widx + 9'd1) == word_total);
  assign in_frame   = (state == LEN) || (state == DATA) || (state == CSUM);
  assign tmo        = in_frame && !rx_valid && (tcnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    data_byte = 1'b0;
    fail      = 1'b0;
    pass      = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && (rx_data == HDR_BYTE)) begin
          start    = 1'b1;
          state_nx = LEN;
        end
      end
      LEN: begin
        if (rx_valid) begin
          state_nx = DATA;
        end else if (tmo) begin
          fail     = 1'b1;
          state_nx = IDLE;
        end
      end
      DATA: begin
        if (rx_valid) begin
          data_byte = 1'b1;
          if ((lane == 2'd3) && last_word) state_nx = CSUM;
        end else if (tmo) begin
          fail     = 1'b1;
          state_nx = IDLE;
        end
      end
      CSUM: begin
        if (rx_valid) begin
          if (rx_data == xsum) begin
            pass     = 1'b1;
            state_nx = DONE_ST;
          end else begin
            fail     = 1'b1;
            state_nx = IDLE;
          end
        end else if (tmo) begin
          fail     = 1'b1;
          state_nx = IDLE;
        end
      end
      DONE_ST: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      core_hold <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      len       <= '0;
      widx      <= '0;
      lane      <= '0;
      asm_lo    <= '0;
      xsum      <= '0;
      tcnt      <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;

      // Idle-gap counter; held at zero outside a frame so LEN entry starts fresh
      if (in_frame && !rx_valid) tcnt <= tcnt + 1'b1;
      else                       tcnt <= '0;

      if (start) begin
        busy      <= 1'b1;
        core_hold <= 1'b1;
        err       <= 1'b0;
        widx      <= '0;
        xsum      <= '0;
        lane      <= '0;
      end

      if ((state == LEN) && rx_valid) len <= rx_data;

      if (data_byte) begin
        xsum <= xsum ^ rx_data;
        lane <= lane + 2'd1;
        case (lane)
          2'd0: asm_lo[7:0]   <= rx_data;
          2'd1: asm_lo[15:8]  <= rx_data;
          2'd2: asm_lo[23:16] <= rx_data;
          default: begin
            wr_en   <= 1'b1;
            wr_data <= {rx_data, asm_lo};
            wr_addr <= ADDR_W'(widx);
            widx    <= widx + 9'd1;
          end
        endcase
      end

      if (fail) begin
        err       <= 1'b1;
        busy      <= 1'b0;
        core_hold <= 1'b1;
      end

      if (pass) begin
        done      <= 1'b1;
        busy      <= 1'b0;
        core_hold <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// Scoreboarded bench for imem_loader: frames built from word images, expected
// writes/done pulses queued at issue time and checked by an output monitor.
module tb_imem_loader;

  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(.ADDR_W(8), .HDR_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          when;
  } wr_t;

  wr_t         wq[$];
  int          dq[$];
  logic [31:0] img[256];
  wr_t         me;
  int          dw;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Output monitor: every write and done pulse must match the head of its queue
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (wq.size() == 0) begin
          chk("unexpected_wr", {56'd0, wr_addr}, 64'hFFFF);
        end else begin
          me = wq.pop_front();
          chk("wr_addr", wr_addr, me.addr);
          chk("wr_data", wr_data, me.data);
          chk("wr_cycle", cyc, me.when);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", done, 1'b0);
        end else begin
          dw = dq.pop_front();
          chk("done_cycle", cyc, dw);
        end
      end
    end
  end

  // Called at a negedge; byte is sampled at the next posedge (cycle cyc+1)
  task automatic send_byte(input logic [7:0] b, input int extra);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (extra) @(negedge clk);
  endtask

  task automatic send_frame(input int nw, input bit corrupt, input int maxgap);
    logic [7:0] cs;
    logic [7:0] b;
    logic [7:0] nb;
    wr_t        e;
    cs = 8'h00;
    nb = nw[7:0];
    send_byte(8'hA5, $urandom_range(maxgap, 0));
    send_byte(nb, $urandom_range(maxgap, 0));
    chk("busy_mid", busy, 1'b1);
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < 4; j++) begin
        b  = img[k][8*j +: 8];
        cs = cs ^ b;
        if (j == 3) begin
          e.addr = k;
          e.data = img[k];
          e.when = cyc + 1;
          wq.push_back(e);
        end
        send_byte(b, $urandom_range(maxgap, 0));
      end
    end
    if (corrupt) cs = cs ^ 8'($urandom_range(255, 1));
    else         dq.push_back(cyc + 1);
    send_byte(cs, 0);
    repeat (3) @(negedge clk);
    chk("err_after", err, corrupt);
    chk("hold_after", core_hold, corrupt);
    chk("busy_after", busy, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wr_en"}, wr_en, 1'b0);
    chk({tag, "_wr_addr"}, wr_addr, 8'h00);
    chk({tag, "_wr_data"}, wr_data, 32'h0);
    chk({tag, "_hold"}, core_hold, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] g;
    wr_t        e;
    int         n;
    bit         cor;

    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);

    // Known 2-word image, then same image with a bad checksum, then recovery
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    send_frame(2, 1'b0, 1);
    send_frame(2, 1'b1, 1);
    send_frame(2, 1'b0, 1);

    // Leading non-header bytes must be dropped
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_byte(8'h5A, 1);
    img[0] = $urandom;
    send_frame(1, 1'b0, 1);

    // Timeout mid-word: no write for the partial word
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    repeat (44) @(negedge clk);
    chk("tmo_early_err", err, 1'b0);
    chk("tmo_early_busy", busy, 1'b1);
    for (int i = 0; i < 20 && !err; i++) @(negedge clk);
    chk("tmo_err", err, 1'b1);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_hold", core_hold, 1'b1);

    // Full 256-word image
    for (int k = 0; k < 256; k++) begin
      g = k[7:0];
      img[k] = {g, g, g, g};
    end
    send_frame(256, 1'b0, 0);

    // Randomized frames with garbage prefixes and occasional bad checksums
    repeat (8) begin
      n   = $urandom_range(12, 1);
      cor = ($urandom_range(2, 0) == 0);
      for (int k = 0; k < n; k++) img[k] = $urandom;
      repeat ($urandom_range(3, 0)) begin
        g = 8'($urandom_range(255, 0));
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, $urandom_range(2, 0));
      end
      send_frame(n, cor, 3);
    end

    // Reset after six data bytes, then a clean reload from address 0
    for (int k = 0; k < 3; k++) img[k] = $urandom;
    send_byte(8'hA5, 1);
    send_byte(8'h03, 1);
    for (int j = 0; j < 6; j++) begin
      if (j == 3) begin
        e.addr = 0;
        e.data = img[0];
        e.when = cyc + 1;
        wq.push_back(e);
      end
      send_byte(img[j / 4][8*(j % 4) +: 8], 1);
    end
    rst = 1'b1;
    #2;
    check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(3, 1'b0, 1);

    repeat (5) @(negedge clk);
    chk("wq_drained", wq.size(), 0);
    chk("dq_drained", dq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
